// File: rtl/pwm_ramp_ctrl_if.sv
// Configuration/duty bus between the PWM top level and the ramp sequencer.
// The master drives configuration and strobes; the slave returns duty and status.
interface pwm_ramp_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic          period_end;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [DW-1:0] step;
  logic          loop;
  logic          start;
  logic          stop;
  logic [DW-1:0] duty;
  logic          duty_upd;
  logic          busy;
  logic          done;
  logic [1:0]    idx;

  modport master (
    output period_end, wr_en, wr_addr, wr_data, step, loop, start, stop,
    input  duty, duty_upd, busy, done, idx
  );

  modport slave (
    input  period_end, wr_en, wr_addr, wr_data, step, loop, start, stop,
    output duty, duty_upd, busy, done, idx
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: ramps PWM duty through a 4-entry (target, hold) table,
// updating duty only on PWM period boundaries.
module pwm_ramp_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned HOLD_W  = 8,
  parameter int unsigned ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pwm_ramp_ctrl_if.slave     bus
);

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, DONE} state_t;

  state_t            state, state_n;
  logic [DW-1:0]     target_q [ENTRIES];
  logic [HOLD_W-1:0] hold_q   [ENTRIES];
  logic [DW-1:0]     duty_q, duty_n;
  logic              upd_q, upd_n;
  logic [IDX_W-1:0]  idx_q, idx_n, sel_idx;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              wr_ok;

  logic [DW-1:0]     sel_target;
  logic signed [DW:0] diff;
  logic [DW:0]       mag;
  logic              reach;
  logic [DW-1:0]     ramp_duty;

  assign bus.duty     = duty_q;
  assign bus.duty_upd = upd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.idx      = idx_q;

  // Ramp step toward the entry being entered (next entry when leaving HOLD).
  always_comb begin
    sel_idx    = (state == HOLD) ? idx_q + IDX_W'(1) : idx_q;
    sel_target = target_q[sel_idx];
    diff       = $signed({1'b0, sel_target}) - $signed({1'b0, duty_q});
    mag        = diff[DW] ? (DW+1)'(-diff) : (DW+1)'(diff);
    reach      = (bus.step == '0) || (mag <= {1'b0, bus.step});
    if (reach)
      ramp_duty = sel_target;
    else if (diff[DW])
      ramp_duty = duty_q - bus.step;
    else
      ramp_duty = duty_q + bus.step;
  end

  // Next-state and registered-output values; stop overrides everything.
  always_comb begin
    state_n    = state;
    duty_n     = duty_q;
    idx_n      = idx_q;
    hold_cnt_n = hold_cnt;
    if (bus.stop) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state_n = RAMP;
            idx_n   = '0;
          end
        end
        RAMP: begin
          if (bus.period_end) begin
            duty_n = ramp_duty;
            if (reach) begin
              hold_cnt_n = hold_q[idx_q];
              state_n    = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.period_end) begin
            if (hold_cnt != '0) begin
              hold_cnt_n = hold_cnt - HOLD_W'(1);
            end else if (idx_q != IDX_W'(ENTRIES - 1) || bus.loop) begin
              // Entering the next entry applies its first ramp step immediately.
              idx_n  = sel_idx;
              duty_n = ramp_duty;
              if (reach) begin
                hold_cnt_n = hold_q[sel_idx];
                state_n    = HOLD;
              end else begin
                state_n    = RAMP;
              end
            end else begin
              state_n = DONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    upd_n  = (duty_n != duty_q);
    busy_n = (state_n == RAMP) || (state_n == HOLD);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      duty_q   <= '0;
      upd_q    <= 1'b0;
      idx_q    <= '0;
      hold_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      duty_q   <= duty_n;
      upd_q    <= upd_n;
      idx_q    <= idx_n;
      hold_cnt <= hold_cnt_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Table is writable only while no sequence is running.
  assign wr_ok = bus.wr_en && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        target_q[i] <= '0;
        hold_q[i]   <= '0;
      end
    end else if (wr_ok) begin
      if (bus.wr_addr[2])
        hold_q[bus.wr_addr[1:0]]   <= HOLD_W'(bus.wr_data);
      else
        target_q[bus.wr_addr[1:0]] <= DW'(bus.wr_data);
    end
  end

endmodule
